dpram_line_reader: RTL

Read-side client for one port of the team's dual-port line/video RAM (`dpram`, 1-cycle registered read latency, write-enable tied low on this port). On a line-start strobe it fetches `LINE_BYTES` consecutive words from a base address. It double-buffers each word and serialises it MSB-first as pixels, advancing one pixel per pixel-clock-enable. It sits between the RAM's port B and the video output stage, opposite the CPU/loader that writes port A.

---
 rtl/dpram_line_reader_if.sv | 19 +
 rtl/dpram_line_reader.sv | 132 +++++++++++++
 2 files changed

// File: rtl/dpram_line_reader_if.sv
// Read-port bus between dpram_line_reader and port B of the line RAM.
// Address is registered by the reader; data returns one edge later.
interface dpram_line_reader_if #(
  parameter int ADDRWIDTH = 13,
  parameter int DATAWIDTH = 8
);
  logic [ADDRWIDTH-1:0] ram_addr;
  logic [DATAWIDTH-1:0] ram_q;

  modport master (
    output ram_addr,
    input  ram_q
  );

  modport slave (
    input  ram_addr,
    output ram_q
  );
endinterface

// File: rtl/dpram_line_reader.sv
// Line reader: fetches LINE_BYTES words from the RAM read port and
// serialises each word MSB-first, one pixel per pix_ce.
module dpram_line_reader #(
  parameter int ADDRWIDTH  = 13,
  parameter int DATAWIDTH  = 8,
  parameter int LINE_BYTES = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 line_start,
  input  logic [ADDRWIDTH-1:0] base_addr,
  input  logic                 pix_ce,
  dpram_line_reader_if.master  ram,
  output logic                 pixel,
  output logic                 pixel_valid,
  output logic                 busy,
  output logic                 line_done
);
  localparam int CW = $clog2(LINE_BYTES + 1);
  localparam int BW = $clog2(DATAWIDTH);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] PREFETCH = 2'd1;
  localparam logic [1:0] RUN      = 2'd2;

  localparam logic [BW-1:0] LAST_BIT = BW'(DATAWIDTH - 1);
  localparam logic [CW-1:0] LB_CNT   = CW'(LINE_BYTES);
  localparam logic [CW-1:0] FT_INIT  = CW'(LINE_BYTES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [ADDRWIDTH-1:0] ADDR_ONE = ADDRWIDTH'(1);

  logic [1:0]           state;
  logic [DATAWIDTH-1:0] shift;
  logic [DATAWIDTH-1:0] hold;
  logic                 hold_valid;
  logic [BW-1:0]        bitcnt;
  logic [CW-1:0]        words_left;
  logic [CW-1:0]        fetch_left;
  logic [1:0]           cap_pending;
  logic [ADDRWIDTH-1:0] addr;

  logic boundary;
  logic last_word;
  logic more_fetch;

  assign boundary   = (state == RUN) && pix_ce
                      && (bitcnt == LAST_BIT);
  assign last_word  = (words_left == CNT_ONE);
  assign more_fetch = (fetch_left != '0);

  assign ram.ram_addr = addr;
  assign pixel_valid  = (state == RUN);
  assign pixel        = pixel_valid & shift[DATAWIDTH-1];
  assign busy         = (state != IDLE);

  // cap_pending[1] marks the edge where ram_q holds the requested word
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      shift       <= '0;
      hold        <= '0;
      hold_valid  <= 1'b0;
      bitcnt      <= '0;
      words_left  <= '0;
      fetch_left  <= '0;
      cap_pending <= '0;
      addr        <= '0;
      line_done   <= 1'b0;
    end else begin
      line_done   <= 1'b0;
      cap_pending <= {cap_pending[0], 1'b0};
      if (line_start) begin
        addr        <= base_addr;
        fetch_left  <= FT_INIT;
        words_left  <= LB_CNT;
        hold_valid  <= 1'b0;
        bitcnt      <= '0;
        cap_pending <= 2'b01;
        state       <= PREFETCH;
      end else begin
        unique case (1'b1)
          (state == IDLE): begin
          end
          (state == PREFETCH): begin
            if (cap_pending[1]) begin
              shift  <= ram.ram_q;
              bitcnt <= '0;
              state  <= RUN;
              if (more_fetch) begin
                addr        <= addr + ADDR_ONE;
                fetch_left  <= fetch_left - CNT_ONE;
                cap_pending <= {cap_pending[0], 1'b1};
              end
            end
          end
          (state == RUN): begin
            if (pix_ce && bitcnt != LAST_BIT) begin
              shift  <= {shift[DATAWIDTH-2:0], 1'b0};
              bitcnt <= bitcnt + BW'(1);
            end else if (boundary) begin
              words_left <= words_left - CNT_ONE;
              if (last_word) begin
                state     <= IDLE;
                line_done <= 1'b1;
              end else begin
                shift      <= hold;
                hold_valid <= 1'b0;
                bitcnt     <= '0;
                if (more_fetch) begin
                  addr        <= addr + ADDR_ONE;
                  fetch_left  <= fetch_left - CNT_ONE;
                  cap_pending <= {cap_pending[0], 1'b1};
                end
              end
            end
            if (cap_pending[1]) begin
              hold       <= ram.ram_q;
              hold_valid <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // a refill must always land before the word it feeds is needed
  underrun_chk: assert property (
    @(posedge clock) disable iff (!reset_n)
    !(boundary && !line_start && !last_word && !hold_valid)
  );
endmodule
